// File: rtl/chain_mix_sequencer_if.sv
// Handshake/control bundle between the chain mix sequencer and its controller.
interface chain_mix_sequencer_if #(
    parameter int SEL_W   = 7,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               abort;
    logic [DWELL_W-1:0] flush_cycles;
    logic [DWELL_W-1:0] dwell_cycles;
    logic               pump_ready;
    logic               carrier_open;
    logic               valve_open;
    logic [SEL_W-1:0]   valve_sel;
    logic               busy;
    logic               done;
    logic               aborted;

    modport master (
        output start, abort, flush_cycles, dwell_cycles, pump_ready,
        input  carrier_open, valve_open, valve_sel, busy, done, aborted
    );

    modport slave (
        input  start, abort, flush_cycles, dwell_cycles, pump_ready,
        output carrier_open, valve_open, valve_sel, busy, done, aborted
    );
endinterface

// File: rtl/chain_mix_sequencer.sv
// Chain mix sequencer: primes the carrier inlet, then doses reagent inlets
// k0..k(N_STAGES-1) in order, waiting for pump pressure before every dose.
// Outputs are registered alongside the state so they change on the same edge.
module chain_mix_sequencer #(
    parameter int N_STAGES = 128,
    parameter int SEL_W    = 7,
    parameter int DWELL_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    chain_mix_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        WAIT_PUMP,
        DOSE,
        SETTLE,
        DONE,
        ABORT
    } state_t;

    localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(N_STAGES - 1);

    state_t             state;
    logic [SEL_W-1:0]   stage_idx;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;

    // Sequencer FSM; outputs are assigned from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            stage_idx        <= '0;
            cnt              <= '0;
            dwell_q          <= '0;
            bus.carrier_open <= 1'b0;
            bus.valve_open   <= 1'b0;
            bus.valve_sel    <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.aborted      <= 1'b0;
        end else begin
            bus.carrier_open <= 1'b0;
            bus.valve_open   <= 1'b0;
            bus.valve_sel    <= '0;
            bus.done         <= 1'b0;
            bus.aborted      <= 1'b0;

            // Abort overrides every active-sequence transition; valves close on this edge.
            if (bus.abort && (state == PRIME || state == WAIT_PUMP ||
                              state == DOSE  || state == SETTLE)) begin
                state       <= ABORT;
                bus.aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            dwell_q   <= bus.dwell_cycles;
                            stage_idx <= '0;
                            bus.busy  <= 1'b1;
                            if (bus.flush_cycles != '0) begin
                                state            <= PRIME;
                                cnt              <= bus.flush_cycles - 1'b1;
                                bus.carrier_open <= 1'b1;
                            end else begin
                                state <= WAIT_PUMP;
                            end
                        end
                    end
                    PRIME: begin
                        if (cnt == '0) begin
                            state <= WAIT_PUMP;
                        end else begin
                            cnt              <= cnt - 1'b1;
                            bus.carrier_open <= 1'b1;
                        end
                    end
                    WAIT_PUMP: begin
                        if (bus.pump_ready) begin
                            state          <= DOSE;
                            cnt            <= (dwell_q == '0) ? '0 : dwell_q - 1'b1;
                            bus.valve_open <= 1'b1;
                            bus.valve_sel  <= stage_idx;
                        end
                    end
                    DOSE: begin
                        if (cnt == '0) begin
                            state <= SETTLE;
                        end else begin
                            cnt            <= cnt - 1'b1;
                            bus.valve_open <= 1'b1;
                            bus.valve_sel  <= stage_idx;
                        end
                    end
                    SETTLE: begin
                        if (stage_idx == LAST_STAGE) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            stage_idx <= stage_idx + 1'b1;
                            state     <= WAIT_PUMP;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    ABORT: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chain_mix_sequencer.sv
// Scoreboard bench for chain_mix_sequencer with four stages.
module tb_chain_mix_sequencer;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    chain_mix_sequencer_if #(.SEL_W(SW), .DWELL_W(DW)) bus ();

    chain_mix_sequencer #(.N_STAGES(N), .SEL_W(SW), .DWELL_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind: 0 carrier_open, 1 valve_open, 2 done, 3 aborted
    typedef struct {
        int kind;
        int sel;
        int rel;
    } ev_t;

    ev_t expq[$];
    int  tests = 0;
    int  fails = 0;
    int  ecnt  = 0;
    int  base  = 0;

    // Edge counter used to time events relative to the start request.
    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: checks valve invariants and pops one expected event per active cycle.
    always @(negedge clk) begin
        int  k;
        int  osel;
        int  orel;
        ev_t e;
        if (rst === 1'b0) begin
            tests++;
            if (bus.carrier_open && bus.valve_open) begin
                fails++;
                $display("FAIL exclusivity: carrier_open=%0b valve_open=%0b, required not both", bus.carrier_open, bus.valve_open);
            end
            tests++;
            if (!bus.valve_open && bus.valve_sel != '0) begin
                fails++;
                $display("FAIL sel_idle: valve_sel=%0d with valve closed, required 0", bus.valve_sel);
            end
            k = -1;
            if (bus.done) k = 2;
            else if (bus.aborted) k = 3;
            else if (bus.valve_open) k = 1;
            else if (bus.carrier_open) k = 0;
            if (k >= 0) begin
                osel = int'(bus.valve_sel);
                orel = ecnt - base;
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected: kind=%0d sel=%0d cyc=%0d, required no event", k, osel, orel);
                end else begin
                    e = expq.pop_front();
                    if (e.kind != k || e.sel != osel || e.rel != orel) begin
                        fails++;
                        $display("FAIL event: got kind=%0d sel=%0d cyc=%0d, expected kind=%0d sel=%0d cyc=%0d",
                                 k, osel, orel, e.kind, e.sel, e.rel);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int k, input int s, input int r);
        ev_t e;
        e.kind = k;
        e.sel  = s;
        e.rel  = r;
        expq.push_back(e);
    endtask

    // Expected event train for a run; stage dstage's pump wait is stretched by dly cycles.
    task automatic push_run(input int fl, input int dw, input int dstage, input int dly);
        int t;
        int d;
        d = (dw == 0) ? 1 : dw;
        for (int r = 1; r <= fl; r++) push(0, 0, r);
        t = 1 + fl;
        for (int s = 0; s < N; s++) begin
            if (s == dstage) t += dly;
            for (int r = 1; r <= d; r++) push(1, s, t + r);
            t += d + 2;
        end
        push(2, 0, t);
    endtask

    task automatic do_start(input int fl, input int dw, input logic ab);
        tick();
        base              = ecnt;
        bus.flush_cycles  = DW'(fl);
        bus.dwell_cycles  = DW'(dw);
        bus.start         = 1'b1;
        bus.abort         = ab;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (ecnt - base < r) tick();
    endtask

    task automatic finish_run(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 80) begin
            tick();
            n++;
        end
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: %0d events still outstanding, expected 0", name, expq.size());
        end
        expq.delete();
        tick();
        tick();
        chk({name, "_busy_after"}, int'(bus.busy), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_carrier"}, int'(bus.carrier_open), 0);
        chk({name, "_valve"},   int'(bus.valve_open),   0);
        chk({name, "_sel"},     int'(bus.valve_sel),    0);
        chk({name, "_busy"},    int'(bus.busy),         0);
        chk({name, "_done"},    int'(bus.done),         0);
        chk({name, "_aborted"}, int'(bus.aborted),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.flush_cycles = '0;
        bus.dwell_cycles = '0;
        bus.pump_ready   = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // 1: flush=2 dwell=3, pump held high
        push_run(2, 3, -1, 0);
        do_start(2, 3, 1'b0);
        wait_rel(5);
        chk("t1_busy_mid", int'(bus.busy), 1);
        finish_run("t1");

        // 2: flush=0 dwell=0, abort alongside start in IDLE is ignored
        push_run(0, 0, -1, 0);
        do_start(0, 0, 1'b1);
        finish_run("t2");

        // 3: pump_ready low for 10 cycles during stage 2's wait
        push_run(2, 3, 2, 10);
        do_start(2, 3, 1'b0);
        wait_rel(13);
        bus.pump_ready = 1'b0;
        wait_rel(23);
        bus.pump_ready = 1'b1;
        finish_run("t3");

        // 4: abort mid-dose of stage 1
        push(0, 0, 1);
        push(0, 0, 2);
        push(1, 0, 4);
        push(1, 0, 5);
        push(1, 0, 6);
        push(1, 1, 9);
        push(1, 1, 10);
        push(3, 0, 11);
        do_start(2, 3, 1'b0);
        wait_rel(10);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        finish_run("t4");

        // 5: asynchronous reset mid-dose, then a fresh run from stage 0
        push(1, 0, 2);
        push(1, 0, 3);
        do_start(0, 3, 1'b0);
        wait_rel(3);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        chk("t5_pending", expq.size(), 0);
        expq.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        push_run(0, 0, -1, 0);
        do_start(0, 0, 1'b0);
        finish_run("t5b");

        // 6: start re-pulsed while busy, dwell/flush changed mid-run
        push_run(1, 2, -1, 0);
        do_start(1, 2, 1'b0);
        wait_rel(5);
        bus.dwell_cycles = DW'(7);
        bus.flush_cycles = DW'(9);
        wait_rel(6);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rel(12);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        finish_run("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
